vga_timing_gen: RTL and testbench

- Raster timing generator: produces the pixel scan position, the visible flag and the sync pulses.
- Sprite and background renderers use display_col, display_row and visible to choose pixel colour.
- The top-level colour mux and the VGA pins use hsync and vsync.
- Single-clock design with an optional pixel clock-enable, so one instance serves any pixel rate derived from the system clock.

---
 rtl/vga_timing_gen.sv | 178 +++++++++++++++++
 tb/tb_vga_timing_gen.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- raster timing generator.
//
// Produces the pixel scan position, the visible flag and the hsync/vsync
// pulses for a VGA-style raster. One pixel advances on every clock that has
// pix_ce high. This lets one instance serve any pixel rate derived from the
// system clock.
//
// Ports:
//   clock        system/pixel clock
//   reset        synchronous, active-high reset
//   pix_ce       pixel clock-enable
//   display_col  presented column, 0..H_TOTAL-1 (not clamped in blanking)
//   display_row  presented row, 0..V_TOTAL-1 (not clamped in blanking)
//   visible      1 while the presented position is in the active area
//   hsync        HS_POL while the presented column is in the sync phase
//   vsync        VS_POL while the presented row is in the sync phase
//   line_start   one-clock pulse when display_col becomes 0
//   frame_start  one-clock pulse when (col,row) becomes (0,0)
//
// Optional build macro VGA_SYNC_DELAY_EN: when it is defined, visible, hsync
// and vsync pass through a SYNC_DELAY-deep shift register that advances on
// pix_ce. This covers the renderers' ROM-read plus colour-register latency.
// display_col, display_row, line_start and frame_start are never delayed.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 1280,
  parameter int H_FRONT    = 48,
  parameter int H_SYNC     = 112,
  parameter int H_BACK     = 248,
  parameter int V_VISIBLE  = 1024,
  parameter int V_FRONT    = 1,
  parameter int V_SYNC     = 3,
  parameter int V_BACK     = 38,
  parameter bit HS_POL     = 1'b1,
  parameter bit VS_POL     = 1'b1,
  parameter int SYNC_DELAY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pix_ce,
  output logic [11:0] display_col,
  output logic [10:0] display_row,
  output logic        visible,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Last count of each phase; the FSM leaves the phase after that count.
  localparam logic [11:0] H_ACT_END  = 12'(H_VISIBLE - 1);
  localparam logic [11:0] H_FP_END   = 12'(H_VISIBLE + H_FRONT - 1);
  localparam logic [11:0] H_SYNC_END = 12'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [10:0] V_ACT_END  = 11'(V_VISIBLE - 1);
  localparam logic [10:0] V_FP_END   = 11'(V_VISIBLE + V_FRONT - 1);
  localparam logic [10:0] V_SYNC_END = 11'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);

  // Phase encoding. The horizontal and vertical FSMs share it.
  localparam logic [1:0] ST_ACT  = 2'd0;
  localparam logic [1:0] ST_FP   = 2'd1;
  localparam logic [1:0] ST_SYNC = 2'd2;
  localparam logic [1:0] ST_BP   = 2'd3;

  if (H_TOTAL > 4096 || V_TOTAL > 2048 ||
      H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
      V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0 ||
      SYNC_DELAY < 0) begin : g_bad_cfg
    $error("vga_timing_gen: illegal timing parameters");
  end

  // The counters hold the position that the next pix_ce cycle presents.
  logic [11:0] h_cnt, h_cnt_nxt;
  logic [10:0] v_cnt, v_cnt_nxt;
  logic [1:0]  h_state, h_state_nxt;
  logic [1:0]  v_state, v_state_nxt;
  logic        h_wrap;
  logic        vis_p0, hs_p0, vs_p0;

  always_comb begin
    h_wrap      = (h_cnt == H_LAST);
    h_cnt_nxt   = h_wrap ? 12'd0 : h_cnt + 12'd1;
    h_state_nxt = h_state;
    case (h_state)
      ST_ACT:  if (h_cnt == H_ACT_END)  h_state_nxt = ST_FP;
      ST_FP:   if (h_cnt == H_FP_END)   h_state_nxt = ST_SYNC;
      ST_SYNC: if (h_cnt == H_SYNC_END) h_state_nxt = ST_BP;
      ST_BP:   if (h_wrap)              h_state_nxt = ST_ACT;
      default:                          h_state_nxt = ST_ACT;
    endcase

    // The vertical FSM steps only on the cycle where the line wraps.
    v_cnt_nxt   = v_cnt;
    v_state_nxt = v_state;
    if (h_wrap) begin
      v_cnt_nxt = (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
      case (v_state)
        ST_ACT:  if (v_cnt == V_ACT_END)  v_state_nxt = ST_FP;
        ST_FP:   if (v_cnt == V_FP_END)   v_state_nxt = ST_SYNC;
        ST_SYNC: if (v_cnt == V_SYNC_END) v_state_nxt = ST_BP;
        ST_BP:   if (v_cnt == V_LAST)     v_state_nxt = ST_ACT;
        default:                          v_state_nxt = ST_ACT;
      endcase
    end
  end

  // Stage p0: present the current position and its decoded flags, then advance.
  always_ff @(posedge clock) begin
    if (reset) begin
      h_cnt       <= 12'd0;
      v_cnt       <= 11'd0;
      h_state     <= ST_ACT;
      v_state     <= ST_ACT;
      display_col <= 12'd0;
      display_row <= 11'd0;
      vis_p0      <= 1'b0;
      hs_p0       <= ~HS_POL;
      vs_p0       <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_ce) begin
        display_col <= h_cnt;
        display_row <= v_cnt;
        vis_p0      <= (h_state == ST_ACT) && (v_state == ST_ACT);
        hs_p0       <= (h_state == ST_SYNC) ? HS_POL : ~HS_POL;
        vs_p0       <= (v_state == ST_SYNC) ? VS_POL : ~VS_POL;
        line_start  <= (h_cnt == 12'd0);
        frame_start <= (h_cnt == 12'd0) && (v_cnt == 11'd0);
        h_cnt       <= h_cnt_nxt;
        v_cnt       <= v_cnt_nxt;
        h_state     <= h_state_nxt;
        v_state     <= v_state_nxt;
      end
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  if (SYNC_DELAY < 1) begin : g_bad_delay
    $error("vga_timing_gen: SYNC_DELAY must be at least 1");
  end

  logic [SYNC_DELAY-1:0] vis_p1, hs_p1, vs_p1;

  // Stage p1: the delay line. It shifts only on pix_ce, so the delay is
  // counted in pixels rather than in clocks.
  always_ff @(posedge clock) begin
    if (reset) begin
      vis_p1 <= '0;
      hs_p1  <= {SYNC_DELAY{~HS_POL}};
      vs_p1  <= {SYNC_DELAY{~VS_POL}};
    end else if (pix_ce) begin
      vis_p1[0] <= vis_p0;
      hs_p1[0]  <= hs_p0;
      vs_p1[0]  <= vs_p0;
      for (int i = 1; i < SYNC_DELAY; i++) begin
        vis_p1[i] <= vis_p1[i-1];
        hs_p1[i]  <= hs_p1[i-1];
        vs_p1[i]  <= vs_p1[i-1];
      end
    end
  end

  assign visible = vis_p1[SYNC_DELAY-1];
  assign hsync   = hs_p1[SYNC_DELAY-1];
  assign vsync   = vs_p1[SYNC_DELAY-1];
`else
  assign visible = vis_p0;
  assign hsync   = hs_p0;
  assign vsync   = vs_p0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen -- self-checking bench for vga_timing_gen.
// It uses a small raster so that full frames fit in a short run. Expected
// outputs come from an arithmetic model: the k-th presented pixel sits at
// col = k % H_TOTAL and row = (k / H_TOTAL) % V_TOTAL. hsync is active-low
// and vsync is active-high, so both polarities are exercised.
module tb_vga_timing_gen;
  localparam int HV = 16, HF = 2, HSY = 3, HB = 4;
  localparam int VV = 6,  VF = 1, VSY = 2, VB = 1;
  localparam int HT = HV + HF + HSY + HB;
  localparam int VT = VV + VF + VSY + VB;
  localparam logic HSP = 1'b0;
  localparam logic VSP = 1'b1;
  localparam int SD = 2;
`ifdef VGA_SYNC_DELAY_EN
  localparam int D = SD;
`else
  localparam int D = 0;
`endif

  logic        clock = 1'b0;
  logic        reset, pix_ce;
  logic [11:0] display_col;
  logic [10:0] display_row;
  logic        visible, hsync, vsync, line_start, frame_start;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
    .HS_POL(HSP), .VS_POL(VSP), .SYNC_DELAY(SD)
  ) dut (
    .clock(clock), .reset(reset), .pix_ce(pix_ce),
    .display_col(display_col), .display_row(display_row),
    .visible(visible), .hsync(hsync), .vsync(vsync),
    .line_start(line_start), .frame_start(frame_start)
  );

  always #5 clock = ~clock;

  int compares = 0;
  int fails = 0;
  int n = 0;
  int e_col = 0, e_row = 0;
  logic e_vis, e_hs, e_vs, e_ls, e_fs;

  // Returns {visible, hsync, vsync} for the k-th presented pixel after reset.
  function automatic logic [2:0] flags(input int k);
    int c, r;
    logic v, h, s;
    if (k < 0) return {1'b0, ~HSP, ~VSP};
    c = k % HT;
    r = (k / HT) % VT;
    v = (c < HV) && (r < VV);
    h = (c >= HV + HF && c < HV + HF + HSY) ? HSP : ~HSP;
    s = (r >= VV + VF && r < VV + VF + VSY) ? VSP : ~VSP;
    return {v, h, s};
  endfunction

  function automatic logic [27:0] act_vec();
    return {display_col, display_row, visible, hsync, vsync, line_start, frame_start};
  endfunction

  function automatic logic [27:0] exp_vec();
    return {12'(e_col), 11'(e_row), e_vis, e_hs, e_vs, e_ls, e_fs};
  endfunction

  // Drives one clock and advances the model. It makes no comparison.
  task automatic step(input logic r, input logic ce);
    reset  = r;
    pix_ce = ce;
    @(posedge clock);
    #1;
    if (r) begin
      n = 0; e_col = 0; e_row = 0;
      e_vis = 1'b0; e_hs = ~HSP; e_vs = ~VSP; e_ls = 1'b0; e_fs = 1'b0;
    end else if (ce) begin
      e_col = n % HT;
      e_row = (n / HT) % VT;
      {e_vis, e_hs, e_vs} = flags(n - D);
      e_ls = (e_col == 0);
      e_fs = (e_col == 0) && (e_row == 0);
      n++;
    end else begin
      e_ls = 1'b0;
      e_fs = 1'b0;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, (i == 2));
      if (act_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL reset cyc=%0d got=%h want=%h", i, act_vec(), exp_vec());
      end
      compares++;
      if ({visible, hsync, vsync, line_start, frame_start} !== {1'b0, ~HSP, ~VSP, 2'b00}) begin
        fails++;
        $display("FAIL reset_flags cyc=%0d got=%b want=%b", i,
                 {visible, hsync, vsync, line_start, frame_start}, {1'b0, ~HSP, ~VSP, 2'b00});
      end
      compares++;
    end
  endtask

  task automatic test_first_pixel();
    step(1'b0, 1'b1);
    if ({display_col, display_row, visible, hsync, vsync, line_start, frame_start}
        !== {12'd0, 11'd0, (D == 0), ~HSP, ~VSP, 2'b11}) begin
      fails++;
      $display("FAIL first_pixel got=%h want col0 row0 vis=%0d ls=1 fs=1", act_vec(), (D == 0));
    end
    compares++;
  endtask

  task automatic test_line();
    int hs_cnt = 0;
    for (int i = 1; i <= HT; i++) begin
      step(1'b0, 1'b1);
      if (hsync === HSP) hs_cnt++;
      if (act_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL line cyc=%0d got=%h want=%h", i, act_vec(), exp_vec());
      end
      compares++;
    end
    if (hs_cnt !== HSY) begin
      fails++;
      $display("FAIL line_hsync_width got=%0d want=%0d", hs_cnt, HSY);
    end
    compares++;
    if ({display_col, display_row, line_start} !== {12'd0, 11'd1, 1'b1}) begin
      fails++;
      $display("FAIL line_restart got col=%0d row=%0d ls=%b want 0 1 1",
               display_col, display_row, line_start);
    end
    compares++;
  endtask

  task automatic test_frame();
    int vs_cnt = 0;
    int last_fs = -1;
    int gap = -1;
    for (int i = 0; i < HT * VT + HT; i++) begin
      step(1'b0, 1'b1);
      if (i < HT * VT && vsync === VSP) vs_cnt++;
      if (frame_start === 1'b1) begin
        if (last_fs >= 0) gap = i - last_fs;
        last_fs = i;
      end
      if (act_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL frame cyc=%0d got=%h want=%h", i, act_vec(), exp_vec());
      end
      compares++;
    end
    if (vs_cnt !== VSY * HT) begin
      fails++;
      $display("FAIL frame_vsync_width got=%0d want=%0d", vs_cnt, VSY * HT);
    end
    compares++;
    if (gap !== -1 && gap !== HT * VT) begin
      fails++;
      $display("FAIL frame_period got=%0d want=%0d", gap, HT * VT);
    end
    compares++;
  endtask

  task automatic test_ce_random();
    logic prev_ls = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)));
      if (act_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL ce_random cyc=%0d got=%h want=%h", i, act_vec(), exp_vec());
      end
      compares++;
      if (prev_ls === 1'b1 && line_start === 1'b1) begin
        fails++;
        $display("FAIL ce_random_pulse cyc=%0d got=2-clock line_start want=1-clock", i);
      end
      prev_ls = line_start;
    end
  endtask

  task automatic test_ce_pattern();
    logic [3:0] pat = 4'b1001;
    for (int i = 0; i < 160; i++) begin
      step(1'b0, pat[3 - (i % 4)]);
      if (act_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL ce_pattern cyc=%0d got=%h want=%h", i, act_vec(), exp_vec());
      end
      compares++;
    end
  endtask

  task automatic test_reset_midframe();
    int i = 0;
    while (i < 2 * HT * VT && !(e_row == 3 && e_col == HV + HF + 1)) begin
      step(1'b0, 1'b1);
      if (act_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL midframe_run cyc=%0d got=%h want=%h", i, act_vec(), exp_vec());
      end
      compares++;
      i++;
    end
    if (!(e_row == 3 && e_col == HV + HF + 1)) begin
      fails++;
      $display("FAIL midframe_reach got row=%0d col=%0d want row=3 col=%0d", e_row, e_col, HV + HF + 1);
    end
    compares++;
    step(1'b1, 1'b1);
    if ({display_col, display_row, visible, hsync, vsync, line_start, frame_start}
        !== {12'd0, 11'd0, 1'b0, ~HSP, ~VSP, 2'b00}) begin
      fails++;
      $display("FAIL midframe_reset got=%h want=%h", act_vec(), exp_vec());
    end
    compares++;
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    if ({display_col, display_row, line_start, frame_start} !== {12'd0, 11'd0, 2'b11}) begin
      fails++;
      $display("FAIL midframe_restart got col=%0d row=%0d ls=%b fs=%b want 0 0 1 1",
               display_col, display_row, line_start, frame_start);
    end
    compares++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 3) != 0));
      if (act_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL back_to_back cyc=%0d got=%h want=%h", i, act_vec(), exp_vec());
      end
      compares++;
      if (reset === 1'b1 && (line_start !== 1'b0 || frame_start !== 1'b0)) begin
        fails++;
        $display("FAIL back_to_back_rst_pulse cyc=%0d got ls=%b fs=%b want 0 0", i, line_start, frame_start);
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    pix_ce = 1'b0;
    test_reset();
    test_first_pixel();
    test_line();
    test_frame();
    test_ce_random();
    test_ce_pattern();
    test_reset_midframe();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end
endmodule
